noc_credit_injector: RTL and testbench

Client-side injection stage feeding a switch `rx` port: it takes packets from a client valid/ready stream, chooses a virtual channel with free downstream credit, and drives the one-hot `vc_target`/`packet` pair that `pi_switch_top` consumes. It tracks per-VC credits returned by the switch on `vc_credit_gnt`. It never issues a flit to a VC whose downstream FIFO could be full. One instance sits between each `verif_client`/PE and its leaf switch port.

---
 rtl/common_pkg.sv | 32 +++
 rtl/rr_vc_arbiter.sv | 46 ++++
 rtl/noc_credit_injector.sv | 108 ++++++++++
 tb/tb_noc_credit_injector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// ============================================================================
// Module      : common_pkg
// Description : Shared defaults, VC one-hot helper and credit sizing helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package common_pkg;

  localparam int DEFAULT_D_W           = 8;
  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;
  localparam int MAX_VC_W              = 32;

  // Injector activity, derived from the credit counters rather than stored
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [MAX_VC_W-1:0] vc_onehot(input int idx);
    logic [MAX_VC_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic int credit_max(input int depth);
    return depth - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_vc_arbiter.sv
// ============================================================================
// Module      : rr_vc_arbiter
// Description : Combinational round-robin pick of the first eligible VC at or
//               after rr_ptr, wrapping. Returns one-hot grant and its index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_vc_arbiter
  import common_pkg::*;
#(
  parameter int VC_W  = DEFAULT_VC_W,
  parameter int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1
) (
  input  logic [VC_W-1:0]  eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [VC_W-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < VC_W; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(VC_W)) begin
        cand = cand - (PTR_W+1)'(VC_W);
      end
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    if (found) begin
      grant = VC_W'(vc_onehot(int'(grant_idx)));
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_credit_injector.sv
// ============================================================================
// Module      : noc_credit_injector
// Description : Client-to-switch injection stage with per-VC credit tracking
//               and round-robin VC selection; one-cycle registered output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module noc_credit_injector
  import common_pkg::*;
#(
  parameter int A_W           = $clog2(2) + 1,
  parameter int D_W           = DEFAULT_D_W,
  parameter int VC_W          = DEFAULT_VC_W,
  parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_addr,
  input  logic [D_W-1:0]       in_data,
  output logic [VC_W-1:0]      tx_vc_target,
  output logic [A_W+D_W-1:0]   tx_packet,
  input  logic [VC_W-1:0]      rx_vc_credit_gnt,
  output logic                 credit_err,
  output logic [31:0]          sent_count
);

  localparam int CR_W  = (VC_FIFO_DEPTH > 2) ? $clog2(VC_FIFO_DEPTH) : 1;
  localparam int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(credit_max(VC_FIFO_DEPTH));

  logic [CR_W-1:0]  credit [VC_W];
  logic [PTR_W-1:0] rr_ptr;
  logic [VC_W-1:0]  eligible;
  logic [VC_W-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic [VC_W-1:0]  overflow;
  logic [0:0]       state;
  logic             accept;

  // Eligibility uses the pre-update count, so a same-cycle return never helps
  generate
    for (genvar g = 0; g < VC_W; g++) begin : g_elig
      assign eligible[g] = (credit[g] != '0);
      assign overflow[g] = rx_vc_credit_gnt[g] && !(accept && grant[g])
                           && (credit[g] == CR_MAX);
    end
  endgenerate

  always_comb begin
    state = (|eligible) ? ST_RUN : ST_IDLE;
  end

  assign in_ready = !rst && (state == ST_RUN);
  assign accept   = in_valid && in_ready;

  rr_vc_arbiter #(
    .VC_W  (VC_W),
    .PTR_W (PTR_W)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_W; v++) begin
        credit[v] <= CR_MAX;
      end
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (accept && grant[v] && !rx_vc_credit_gnt[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end else if (rx_vc_credit_gnt[v] && !(accept && grant[v])
                     && (credit[v] != CR_MAX)) begin
          credit[v] <= credit[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      tx_vc_target <= '0;
      tx_packet    <= '0;
      sent_count   <= '0;
      credit_err   <= 1'b0;
    end else begin
      tx_vc_target <= accept ? grant : '0;
      if (accept) begin
        tx_packet  <= {in_addr, in_data};
        sent_count <= sent_count + 32'd1;
        rr_ptr     <= (grant_idx == PTR_W'(VC_W - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (|overflow) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_credit_injector.sv
// ============================================================================
// Module      : tb_noc_credit_injector
// Description : Directed bench with a behavioural credit/round-robin model
//               compared every cycle, plus literal expectations per scenario.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_noc_credit_injector;

  localparam int NVC  = 2;
  localparam int DEP  = 4;
  localparam int CMAX = DEP - 1;
  localparam int AW   = 2;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AW-1:0]     in_addr = '0;
  logic [DW-1:0]     in_data = '0;
  logic [NVC-1:0]    tx_vc_target;
  logic [AW+DW-1:0]  tx_packet;
  logic [NVC-1:0]    rx_vc_credit_gnt = '0;
  logic              credit_err;
  logic [31:0]       sent_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pat    = 0;

  noc_credit_injector #(
    .A_W           (AW),
    .D_W           (DW),
    .VC_W          (NVC),
    .VC_FIFO_DEPTH (DEP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_addr          (in_addr),
    .in_data          (in_data),
    .tx_vc_target     (tx_vc_target),
    .tx_packet        (tx_packet),
    .rx_vc_credit_gnt (rx_vc_credit_gnt),
    .credit_err       (credit_err),
    .sent_count       (sent_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: credit pool per VC, pointer as plain integer
  int             mcred [NVC];
  int             mrr = 0;
  int             ch;
  int             c;
  logic [NVC-1:0] mtgt = '0;
  logic [AW+DW-1:0] mpkt = '0;
  logic [31:0]    msent = '0;
  logic           merr = 1'b0;

  function automatic logic mready();
    logic any = 1'b0;
    for (int v = 0; v < NVC; v++) if (mcred[v] > 0) any = 1'b1;
    return !rst && any;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NVC; v++) mcred[v] = CMAX;
      mrr = 0; mtgt = '0; mpkt = '0; msent = '0; merr = 1'b0;
    end else begin
      ch = -1;
      if (in_valid) begin
        for (int k = 0; k < NVC; k++) begin
          c = (mrr + k) % NVC;
          if (ch < 0 && mcred[c] > 0) ch = c;
        end
      end
      mtgt = '0;
      if (ch >= 0) begin
        mtgt[ch] = 1'b1;
        mpkt = {in_addr, in_data};
        msent = msent + 1;
        mrr = (ch + 1) % NVC;
        mcred[ch] = mcred[ch] - 1;
      end
      for (int v = 0; v < NVC; v++) begin
        if (rx_vc_credit_gnt[v]) begin
          if (mcred[v] >= CMAX) merr = 1'b1;
          else mcred[v] = mcred[v] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", 32'(in_ready), 32'(mready()));
      chk("model_tx_vc_target", 32'(tx_vc_target), 32'(mtgt));
      if (mtgt != '0) chk("model_tx_packet", 32'(tx_packet), 32'(mpkt));
      chk("model_sent_count", sent_count, msent);
      chk("model_credit_err", 32'(credit_err), 32'(merr));
    end
  end

  // Inputs change 2 time units after the edge and are held for the next edge
  task automatic drive(input logic v, input logic [NVC-1:0] g, input logic r);
    @(posedge clk);
    #2;
    in_valid = v;
    rx_vc_credit_gnt = g;
    rst = r;
    pat++;
    in_addr = AW'(pat * 3);
    in_data = DW'(pat * 37 + 5);
  endtask

  logic [NVC-1:0] seq [$];

  initial begin
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b0, 2'b00, 1'b1);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_tx_vc_target", 32'(tx_vc_target), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);

    // Release reset with valid held and no returns: six alternating flits
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 1'b0);
      @(negedge clk);
      if (i == 0) chk("first_cycle_in_ready", 32'(in_ready), 32'h1);
      if (tx_vc_target != '0) seq.push_back(tx_vc_target);
    end
    chk("burst_flit_count", 32'(seq.size()), 32'd6);
    for (int i = 0; i < seq.size(); i++) begin
      chk("burst_vc_order", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    chk("burst_sent_count", sent_count, 32'd6);
    chk("burst_in_ready_low", 32'(in_ready), 32'h0);

    // Single VC0 return re-enables exactly one flit
    drive(1'b0, 2'b01, 1'b0);
    @(negedge clk);
    chk("return_not_yet_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("return_ready_next", 32'(in_ready), 32'h1);
    drive(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("return_flit_vc0", 32'(tx_vc_target), 32'h1);
    chk("return_drained", 32'(in_ready), 32'h0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("return_no_extra", 32'(tx_vc_target), 32'h0);

    // Return arriving with valid cannot be used in that same cycle
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("same_cycle_no_flit", 32'(tx_vc_target), 32'h0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("same_cycle_flit_next", 32'(tx_vc_target), 32'h1);

    // VC1 at one credit: consume and return together keeps it at one
    drive(1'b0, 2'b10, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("vc1_swap_flit", 32'(tx_vc_target), 32'h2);
    chk("vc1_swap_still_ready", 32'(in_ready), 32'h1);
    chk("vc1_swap_no_err", 32'(credit_err), 32'h0);
    drive(1'b1, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("vc1_last_flit", 32'(tx_vc_target), 32'h2);
    chk("vc1_now_empty", 32'(in_ready), 32'h0);

    // Refill to full, then overflow on both VCs
    for (int i = 0; i < CMAX; i++) drive(1'b0, 2'b11, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("full_no_err", 32'(credit_err), 32'h0);
    drive(1'b0, 2'b11, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("overflow_err_set", 32'(credit_err), 32'h1);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("overflow_sat_drain", 32'(in_ready), 32'h0);
    chk("overflow_err_sticky", 32'(credit_err), 32'h1);

    // Reset while a flit is registered
    drive(1'b0, 2'b11, 1'b0);
    drive(1'b1, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("pre_reset_flit", 32'(tx_vc_target != '0), 32'h1);
    chk("in_reset_ready_low", 32'(in_ready), 32'h0);
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("post_reset_target", 32'(tx_vc_target), 32'h0);
    chk("post_reset_sent", sent_count, 32'h0);
    chk("post_reset_err", 32'(credit_err), 32'h0);
    chk("post_reset_ready", 32'(in_ready), 32'h1);

    // A short mixed run after reset for the model comparison
    for (int i = 0; i < 20; i++) begin
      drive(1'(i % 3 != 2), 2'(i % 4 == 1 ? 1 : (i % 5 == 3 ? 2 : 0)), 1'b0);
    end
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
